// File: rtl/shared_port_arbiter.sv
// -----------------------------------------------------------------------------
// shared_port_arbiter
//
// Round-robin arbiter that shares one resource port among N_REQ requesters.
// A requester is granted, its burst is forwarded beat by beat to the resource,
// then the block waits for the single response, routes it back to the granted
// requester and re-arbitrates. A response timeout releases a hung resource.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_req_valid       per-requester beat valid                [N_REQ]
//   i_req_data        per-requester beat data, k at [k*DW +: DW]
//   i_req_last        per-requester last beat of burst        [N_REQ]
//   o_req_ready       per-requester beat accepted             [N_REQ]
//   o_rsp_valid       per-requester one-cycle response pulse  [N_REQ]
//   o_rsp_data        registered response data, held between pulses
//   o_res_valid/data/last   beat toward the resource
//   i_res_ready       resource accepts beat
//   i_res_rsp_valid   resource response valid (single cycle)
//   i_res_rsp_data    resource response data
//   o_grant_id        current / last granted requester
//   o_busy            transaction in progress (XFER or WAIT_RSP)
//   o_timeout         one-cycle pulse when the response timed out
// -----------------------------------------------------------------------------
module shared_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [N_REQ-1:0]              i_req_last,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic [N_REQ-1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_res_valid,
    output logic [DATA_WIDTH-1:0]         o_res_data,
    output logic                          o_res_last,
    input  logic                          i_res_ready,
    input  logic                          i_res_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         i_res_rsp_data,
    output logic [$clog2(N_REQ)-1:0]      o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;        // highest-priority requester for next round
    logic [IDW-1:0]   grant;      // granted requester, drives o_grant_id
    logic [IDW-1:0]   grant_inc;  // (grant + 1) mod N_REQ
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic [CW-1:0]    cnt;

    logic             beat_fire;
    logic             last_fire;
    logic             rsp_hit;
    logic             tmo_hit;

    // ------------------------------------------------------------------
    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, otherwise synthesis infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // Explicit wrap so non-power-of-two N_REQ stays in range.
    assign grant_inc = (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);

    assign beat_fire = (state == XFER) && i_req_valid[grant] && i_res_ready;
    assign last_fire = beat_fire && i_req_last[grant];
    assign rsp_hit   = (state == WAIT_RSP) && i_res_rsp_valid;
    // A response in the same cycle as the limit takes precedence.
    assign tmo_hit   = (state == WAIT_RSP) && !i_res_rsp_valid && (cnt >= CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (win_found)           state_nxt = XFER;
            XFER:     if (last_fire)           state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_hit || tmo_hit)  state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pass-through of the granted requester during XFER)
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready = '0;
        o_res_valid = 1'b0;
        o_res_data  = '0;
        o_res_last  = 1'b0;
        o_busy      = (state != IDLE);
        if (state == XFER) begin
            o_res_valid        = i_req_valid[grant];
            o_res_data         = i_req_data[grant*DATA_WIDTH +: DATA_WIDTH];
            o_res_last         = i_req_last[grant];
            o_req_ready[grant] = i_res_ready;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: grant, pointer, timeout counter, response
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr         <= '0;
            grant       <= '0;
            cnt         <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_timeout   <= 1'b0;
        end else begin
            o_rsp_valid <= '0;
            o_timeout   <= 1'b0;

            if (state == IDLE && win_found) grant <= win_idx;

            // Counter saturates so a stuck WAIT_RSP can never wrap it to 0.
            if (last_fire)
                cnt <= '0;
            else if (state == WAIT_RSP && cnt != CNT_MAX)
                cnt <= cnt + CW'(1);

            if (rsp_hit) begin
                o_rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << grant;
                o_rsp_data  <= i_res_rsp_data;
                ptr         <= grant_inc;
            end else if (tmo_hit) begin
                o_timeout   <= 1'b1;
                ptr         <= grant_inc;
            end
        end
    end

    assign o_grant_id = grant;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_port_arbiter
//
// Directed bench for shared_port_arbiter (N_REQ=4, DATA_WIDTH=8, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge, outputs are checked 2 time
// units after it. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_shared_port_arbiter;

    localparam int N_REQ      = 4;
    localparam int DATA_WIDTH = 8;
    localparam int TIMEOUT    = 8;

    logic                        clk;
    logic                        rst_n;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic                        res_valid;
    logic [DATA_WIDTH-1:0]       res_data;
    logic                        res_last;
    logic                        res_ready;
    logic                        res_rsp_valid;
    logic [DATA_WIDTH-1:0]       res_rsp_data;
    logic [1:0]                  grant_id;
    logic                        busy;
    logic                        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    shared_port_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_res_valid     (res_valid),
        .o_res_data      (res_data),
        .o_res_last      (res_last),
        .i_res_ready     (res_ready),
        .i_res_rsp_valid (res_rsp_valid),
        .i_res_rsp_data  (res_rsp_data),
        .o_grant_id      (grant_id),
        .o_busy          (busy),
        .o_timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [DATA_WIDTH-1:0] v);
        req_data[k*DATA_WIDTH +: DATA_WIDTH] = v;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        res_ready     = 1'b0;
        res_rsp_valid = 1'b0;
        res_rsp_data  = '0;

        // ---------------- reset state ----------------
        step();
        #1;
        check("rst_busy",      busy,      0);
        check("rst_grant",     grant_id,  0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_timeout",   timeout,   0);
        check("rst_res_valid", res_valid, 0);
        step();
        rst_n = 1'b1;
        step();

        // ---------------- single requester 2, 3-beat burst ----------------
        req_valid = 4'b0100;
        set_data(2, 8'h11);
        res_ready = 1'b1;
        #1;
        check("t1_arb_latency_valid", res_valid, 0);
        check("t1_arb_latency_busy",  busy,      0);
        step();
        #1;
        check("t1_grant",    grant_id,  2);
        check("t1_busy",     busy,      1);
        check("t1_beat0",    res_data,  8'h11);
        check("t1_rvalid0",  res_valid, 1);
        check("t1_ready0",   req_ready, 4'b0100);
        step();
        set_data(2, 8'h22);
        #1;
        check("t1_beat1",    res_data,  8'h22);
        step();
        set_data(2, 8'h33);
        req_last = 4'b0100;
        #1;
        check("t1_beat2",    res_data,  8'h33);
        check("t1_last",     res_last,  1);
        step();
        req_valid = '0;
        req_last  = '0;
        #1;
        check("t1_wait_busy",  busy,      1);
        check("t1_wait_valid", res_valid, 0);
        step();
        res_rsp_valid = 1'b1;
        res_rsp_data  = 8'hA5;
        step();
        res_rsp_valid = 1'b0;
        #1;
        check("t1_rsp_valid", rsp_valid, 4'b0100);
        check("t1_rsp_data",  rsp_data,  8'hA5);
        check("t1_busy_drop", busy,      0);
        step();
        #1;
        check("t1_rsp_pulse_end", rsp_valid, 0);
        check("t1_rsp_data_hold", rsp_data,  8'hA5);

        // Response outside WAIT_RSP is ignored.
        res_rsp_valid = 1'b1;
        res_rsp_data  = 8'h5A;
        step();
        res_rsp_valid = 1'b0;
        #1;
        check("stray_rsp_valid", rsp_valid, 0);
        check("stray_rsp_busy",  busy,      0);
        check("stray_rsp_data",  rsp_data,  8'hA5);

        // ---------------- round robin, all valid ----------------
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < N_REQ; k++) set_data(k, DATA_WIDTH'(8'h10 + k));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] g;
            g = 2'(k % 4);
            step();
            #1;
            check("rr_grant", grant_id,  g);
            check("rr_ready", req_ready, 4'b0001 << g);
            check("rr_data",  res_data,  8'h10 + g);
            step();
            res_rsp_valid = 1'b1;
            res_rsp_data  = 8'h40 + 8'(k);
            #1;
            check("rr_wait_valid", res_valid, 0);
            step();
            res_rsp_valid = 1'b0;
            if (k == 4) req_valid = '0;
            #1;
            check("rr_rsp_valid", rsp_valid, 4'b0001 << g);
            check("rr_rsp_data",  rsp_data,  8'h40 + 8'(k));
        end

        // ---------------- backpressure, requester 1 (ptr is 1) ----------------
        req_last  = '0;
        req_valid = 4'b0010;
        set_data(1, 8'hB1);
        res_ready = 1'b1;
        #1;
        check("bp_idle_valid", res_valid, 0);
        step();
        req_valid = 4'b1010;
        set_data(3, 8'hEE);
        #1;
        check("bp_grant",   grant_id,  1);
        check("bp_valid0",  res_valid, 1);
        check("bp_data0",   res_data,  8'hB1);
        check("bp_ready0",  req_ready, 4'b0010);
        step();
        set_data(1, 8'hB2);
        req_last  = 4'b0010;
        res_ready = 1'b0;
        #1;
        check("bp_stall_ready", req_ready, 4'b0000);
        check("bp_stall_data",  res_data,  8'hB2);
        check("bp_stall_valid", res_valid, 1);
        step();
        req_valid = 4'b1000;
        #1;
        check("bp_blocked_valid", res_valid, 0);
        check("bp_blocked_ready", req_ready, 4'b0000);
        check("bp_blocked_busy",  busy,      1);
        step();
        req_valid = 4'b1010;
        res_ready = 1'b1;
        #1;
        check("bp_resume_ready", req_ready, 4'b0010);
        check("bp_resume_data",  res_data,  8'hB2);
        check("bp_resume_last",  res_last,  1);
        step();
        req_valid = '0;
        req_last  = '0;
        #1;
        check("bp_wait_busy",  busy,      1);
        check("bp_wait_ready", req_ready, 4'b0000);

        // ---------------- timeout: pulse 8 cycles after WAIT_RSP entry ----------
        repeat (7) step();
        #1;
        check("to_not_yet", timeout, 0);
        check("to_busy",    busy,    1);
        step();
        #1;
        check("to_pulse",     timeout,   1);
        check("to_no_rsp",    rsp_valid, 0);
        check("to_idle",      busy,      0);
        step();
        #1;
        check("to_pulse_end", timeout, 0);

        // ---------------- response at counter limit (ptr is 2) ----------------
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        step();
        #1;
        check("lim_grant_ptr_adv", grant_id, 2);
        step();
        req_valid = '0;
        repeat (7) step();
        res_rsp_valid = 1'b1;
        res_rsp_data  = 8'h77;
        #1;
        check("lim_pre_timeout", timeout, 0);
        step();
        res_rsp_valid = 1'b0;
        #1;
        check("lim_rsp_valid",  rsp_valid, 4'b0100);
        check("lim_rsp_data",   rsp_data,  8'h77);
        check("lim_no_timeout", timeout,   0);
        step();
        #1;
        check("lim_no_late_timeout", timeout, 0);

        // ---------------- reset mid-XFER (ptr is 3) ----------------
        req_valid = 4'b0010;
        req_last  = '0;
        set_data(1, 8'hD1);
        step();
        #1;
        check("mid_grant", grant_id, 1);
        step();
        set_data(1, 8'hD2);
        #1;
        check("mid_busy",  busy,      1);
        check("mid_valid", res_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy,      0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_data",  res_data,  0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_grant", grant_id,  0);
        check("mid_rst_rsp",   rsp_valid, 0);
        check("mid_rst_to",    timeout,   0);
        step();
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        step();
        #1;
        check("post_rst_grant", grant_id, 0);
        check("post_rst_busy",  busy,     1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_port_arbiter.md
Name: shared_port_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one master-side resource port among N_REQ requesters.
- Resource port signals: request valid/data/last, ready, response valid/data.
- The block grants one requester at a time and forwards that requester's burst to the resource.
- It waits for the single response, routes the response back to the granted requester, then re-arbitrates. A response timeout guards against a hung resource.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, request/response payload width
TIMEOUT, 64, max cycles in WAIT_RSP before abort (>=2)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_req_valid  input  N_REQ  per-requester request beat valid
i_req_data  input  N_REQ*DATA_WIDTH  per-requester beat data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
i_req_last  input  N_REQ  per-requester last beat of burst
o_req_ready  output  N_REQ  per-requester beat accepted
o_rsp_valid  output  N_REQ  per-requester response pulse
o_rsp_data  output  DATA_WIDTH  response data (shared, qualified by o_rsp_valid)
o_res_valid  output  1  beat valid to resource
o_res_data  output  DATA_WIDTH  beat data to resource
o_res_last  output  1  last beat to resource
i_res_ready  input  1  resource accepts beat
i_res_rsp_valid  input  1  resource response valid (single-cycle)
i_res_rsp_data  input  DATA_WIDTH  resource response data
o_grant_id  output  $clog2(N_REQ)  currently/last granted requester
o_busy  output  1  state != IDLE
o_timeout  output  1  one-cycle pulse on response timeout

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - state=IDLE, priority pointer=0, o_grant_id=0, timeout counter=0.
  - o_timeout=0, o_rsp_valid=0, o_rsp_data=0.
  - Combinational outputs evaluate to 0 in IDLE.
- States:
  - IDLE: no grant.
    - At any clock edge with |i_req_valid, register the winner and go to XFER.
    - Winner = first set bit of i_req_valid searching from ptr, ptr+1, ... wrapping modulo N_REQ.
    - 1-cycle arbitration latency: no beat moves in the cycle the request first appears.
  - XFER: combinational pass-through for granted index g.
    - o_res_valid=i_req_valid[g], o_res_data=i_req_data[g], o_res_last=i_req_last[g].
    - o_req_ready[g]=i_res_ready; all other o_req_ready bits 0.
    - A beat transfers when o_res_valid && i_res_ready.
    - Transfer with last=1: go to WAIT_RSP, clear timeout counter.
    - Non-granted requesters stay blocked regardless of their valid.
  - WAIT_RSP: o_res_valid=0, all o_req_ready=0, counter increments each cycle.
    - On i_res_rsp_valid: next cycle o_rsp_valid[g]=1 for one cycle, o_rsp_data=i_res_rsp_data (registered).
    - Then go to IDLE, ptr=(g+1) mod N_REQ.
    - If the counter reaches TIMEOUT-1 without a response: o_timeout pulses next cycle, no o_rsp_valid, go to IDLE, ptr=(g+1) mod N_REQ.
    - Response and timeout in the same cycle: response wins, no timeout pulse.
- i_res_rsp_valid outside WAIT_RSP is ignored: no o_rsp_valid, no state change.
- Fairness:
  - A requester that was just served has lowest priority next round.
  - With all requesters continuously valid, grants go 0,1,2,...,N_REQ-1,0.
- Re-arbitration: the earliest next grant is one cycle after the return to IDLE, so each transaction has at least one idle gap cycle.
- A single-beat burst (valid && last in the first XFER cycle) is legal.
- o_rsp_data holds its value between pulses.
- o_grant_id is registered at grant and held until the next grant.
- o_busy=1 in XFER and WAIT_RSP.
- Reset mid-transaction aborts immediately to IDLE. No response or timeout pulse is generated, and ptr returns to 0.
- Counter width is $clog2(TIMEOUT)+1, and it saturates rather than wraps.

Test Plan:
- Single requester 2, 3-beat burst 0x11,0x22,0x33(last), ready=1, response 0xA5 two cycles after the last beat.
  - Grant one cycle after valid; beats appear on o_res_data in order.
  - o_rsp_valid=4'b0100 for one cycle with o_rsp_data=0xA5; o_busy drops after.
- All 4 requesters continuously valid, single-beat bursts, immediate responses -> o_grant_id sequence 0,1,2,3,0 with no requester served twice before the others.
- Backpressure: i_res_ready toggling 1,0,0,1 during a 2-beat burst.
  - o_req_ready[g] mirrors i_res_ready.
  - Data is held and no beat is lost or duplicated.
  - A non-granted requester's valid never reaches o_res_valid.
- Timeout with TIMEOUT=8: no response after last beat -> o_timeout pulses exactly 8 cycles after WAIT_RSP entry, no o_rsp_valid, ptr advances.
- Response on the same cycle the counter hits TIMEOUT-1 -> o_rsp_valid pulse and no o_timeout.
- Assert i_rst_n low mid-XFER after the 1st beat -> all outputs 0 immediately. After release, requester 0 wins first despite the earlier grant.
